fram_port_arbiter: RTL
======================

Name: fram_port_arbiter

Overview:
- Shares the single-port feature SRAM between three requesters: the host BRAM-controller port, the conv engine read port, and the conv engine write-back port.
- The host always has priority because the BRAM controller cannot be stalled. The two engine ports alternate round-robin in the remaining cycles.
- It registers the SRAM command and tags each read so that returned data goes back to the requester that issued it.
- It sits between the accelerator top level and the feature SRAM macro.

Parameters:
- ADDR_WIDTH, 12, SRAM word-address width.
- DATA_WIDTH, 32, SRAM data width.
- RD_LATENCY, 1, SRAM read latency in clocks. Legal range 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_en  in  1  host access strobe
- host_we  in  1  host write enable; qualified by host_en
- host_addr  in  ADDR_WIDTH  host word address
- host_wdata  in  DATA_WIDTH  host write data
- host_rdata  out  DATA_WIDTH  host read data; holding register
- eng_rd_req  in  1  engine read request; held until granted
- eng_rd_addr  in  ADDR_WIDTH  engine read address
- eng_rd_gnt  out  1  engine read accepted this cycle
- eng_rd_rvalid  out  1  engine read data valid; 1-cycle pulse
- eng_rd_rdata  out  DATA_WIDTH  engine read data
- eng_wr_req  in  1  engine write request; held until granted
- eng_wr_addr  in  ADDR_WIDTH  engine write address
- eng_wr_data  in  DATA_WIDTH  engine write data
- eng_wr_gnt  out  1  engine write accepted this cycle
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data
- stall_cnt  out  32  engine stall-cycle count; present only with the optional feature
- stall_clr  in  1  synchronous clear of stall_cnt; present only with the optional feature

Behaviour:
- Reset values: all outputs 0, RR pointer set to favour read, tag pipeline cleared.
- Arbitration is combinational within cycle N:
  - host_en=1 wins; both engine grants are 0.
  - Otherwise, a lone engine requester is granted.
  - If both engine ports request, the RR pointer decides. The pointer toggles only when the RR grant was actually used.
- Grants are pulses. A requester must hold req/addr/data stable until it sees its gnt.
- SRAM command timing:
  - The winning command is registered and driven on sram_* in cycle N+1.
  - sram_en=0 in idle cycles; sram_addr and sram_wdata hold their last values.
- Read tag pipeline: depth 1+RD_LATENCY, each entry {valid, owner}. Reads are tagged; writes are not.
- Read return:
  - When a tag exits the pipeline, sram_rdata is captured into the owner's data register.
  - The captured data is visible in cycle N+2+RD_LATENCY, with eng_rd_rvalid pulsing that cycle for engine reads.
  - Read latency is 3 cycles with RD_LATENCY=1.
- host_rdata holds its value until the next host read returns. eng_rd_rdata holds similarly.
- Pipelining: back-to-back reads are accepted every cycle. Returns come back strictly in issue order.
- Same-address hazards:
  - Accesses are serialized in grant order.
  - A read issued after a write to the same address returns the new data. This relies on SRAM write-first or later-cycle access.
- Reset mid-operation: in-flight tags are discarded. No rvalid appears after release and the data registers read 0.
- No FIFOs. The arbiter never drops an engine request; it is only delayed while host_en is active.

Optional Feature:
- Macro: FRAM_ARB_STATS_EN.
- Defined:
  - stall_cnt increments each cycle in which an engine request is pending but no engine grant is issued because of host_en.
  - stall_cnt saturates at 0xFFFFFFFF.
  - stall_clr=1 clears it to 0; clear takes precedence over increment.
- Undefined: stall_cnt and stall_clr ports and their logic are absent.

Test Plan:
1. Host write 0x010←0xDEADBEEF in cycle 10, then host read 0x010 in cycle 11 -> sram_we=1 in cycle 11; host_rdata=0xDEADBEEF from cycle 14 (RD_LATENCY=1).
2. eng_rd_req and eng_wr_req held continuously with no host traffic after reset -> grants alternate rd,wr,rd,wr,… with the first grant going to rd; exactly one gnt per cycle.
3. host_en=1 for cycles 20-22 while eng_rd_req is pending -> eng_rd_gnt=0 in cycles 20-22 and 1 in cycle 23; stall_cnt=3 with FRAM_ARB_STATS_EN.
4. Engine reads addresses 0..7 back-to-back, with SRAM preloaded mem[i]=i*4 -> 8 eng_rd_rvalid pulses in consecutive cycles with data 0,4,…,28; first pulse 3 cycles after the first grant.
5. Assert rst_n low with 2 engine reads in flight, then release -> all outputs 0 during reset; no eng_rd_rvalid after release.
6. Host write 0x020←0x1111 and engine write 0x020←0x2222 requested in the same cycle -> host is written first and the engine write is granted the next cycle; a following host read returns 0x2222.

Source files
------------

// File: rtl/fram_port_arbiter.sv
// fram_port_arbiter: host-priority, round-robin engine arbiter for the single-port feature SRAM.
// Optional FRAM_ARB_STATS_EN adds the stall_cnt/stall_clr engine stall counter.
module fram_port_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_en,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic                  eng_rd_req,
   input  logic [ADDR_WIDTH-1:0] eng_rd_addr,
   output logic                  eng_rd_gnt,
   output logic                  eng_rd_rvalid,
   output logic [DATA_WIDTH-1:0] eng_rd_rdata,
   input  logic                  eng_wr_req,
   input  logic [ADDR_WIDTH-1:0] eng_wr_addr,
   input  logic [DATA_WIDTH-1:0] eng_wr_data,
   output logic                  eng_wr_gnt,
`ifdef FRAM_ARB_STATS_EN
   output logic [31:0]           stall_cnt,
   input  logic                  stall_clr,
`endif
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata
);
   logic                rr_rd;
   logic [RD_LATENCY:0] tag_v, tag_eng;
   logic                tag_out;
   assign eng_rd_gnt = !host_en && eng_rd_req && (!eng_wr_req || rr_rd);
   assign eng_wr_gnt = !host_en && eng_wr_req && (!eng_rd_req || !rr_rd);
   assign tag_out    = tag_v[RD_LATENCY];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_rd         <= 1'b1;
         tag_v         <= '0;
         tag_eng       <= '0;
         sram_en       <= 1'b0;
         sram_we       <= 1'b0;
         sram_addr     <= '0;
         sram_wdata    <= '0;
         host_rdata    <= '0;
         eng_rd_rvalid <= 1'b0;
         eng_rd_rdata  <= '0;
      end else begin
         sram_en <= host_en || eng_rd_gnt || eng_wr_gnt;
         sram_we <= host_en ? host_we : eng_wr_gnt;
         if (host_en) begin
            sram_addr <= host_addr;
            if (host_we) sram_wdata <= host_wdata;
         end else if (eng_rd_gnt) begin
            sram_addr <= eng_rd_addr;
         end else if (eng_wr_gnt) begin
            sram_addr  <= eng_wr_addr;
            sram_wdata <= eng_wr_data;
         end
         // pointer moves only when a contended engine grant is actually issued
         if (!host_en && eng_rd_req && eng_wr_req) rr_rd <= !rr_rd;
         tag_v   <= {tag_v[RD_LATENCY-1:0], (host_en && !host_we) || eng_rd_gnt};
         tag_eng <= {tag_eng[RD_LATENCY-1:0], eng_rd_gnt};
         if (tag_out && !tag_eng[RD_LATENCY]) host_rdata <= sram_rdata;
         if (tag_out && tag_eng[RD_LATENCY]) eng_rd_rdata <= sram_rdata;
         eng_rd_rvalid <= tag_out && tag_eng[RD_LATENCY];
      end
   end
`ifdef FRAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt <= '0;
      else if (stall_clr) stall_cnt <= '0;
      else if (host_en && (eng_rd_req || eng_wr_req) && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule
